// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared constants, FSM states and per-ball constant functions
// Purpose: RGB colour constants, update FSM state enum, and the per-index
//          initial position, speed and colour functions used by ball_multi.
// Ports:   none (package).
package ball_pkg;

  localparam logic [2:0] RGB_BLACK   = 3'b000;
  localparam logic [2:0] RGB_RED     = 3'b001;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_YELLOW  = 3'b011;
  localparam logic [2:0] RGB_BLUE    = 3'b100;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_CYAN    = 3'b110;
  localparam logic [2:0] RGB_WHITE   = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_UPDATE
  } state_e;

  function automatic int ball_init_x(input int k);
    return 16 * k + 16;
  endfunction

  function automatic int ball_init_y(input int k);
    return 12 * k + 12;
  endfunction

  function automatic int ball_spd_x(input int k);
    return (k % 4) + 1;
  endfunction

  function automatic int ball_spd_y(input int k);
    return ((k + 1) % 4) + 1;
  endfunction

  // Colour never 0, so every ball is distinguishable from the background.
  function automatic logic [2:0] ball_colour(input int k);
    return 3'((k % 7) + 1);
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one-frame step of a single axis with edge bounce
// Purpose: combinational position/direction update for one axis of one ball.
// Ports:   i_pos, i_dir (0 = +, 1 = -), i_spd, i_lim in;
//          o_pos_next, o_dir_next out.
module ball_axis_step
  import ball_pkg::*;
#(
  parameter int POS_W = 10
) (
  input  logic [POS_W-1:0] i_pos,
  input  logic             i_dir,
  input  logic [POS_W-1:0] i_spd,
  input  logic [POS_W-1:0] i_lim,
  output logic [POS_W-1:0] o_pos_next,
  output logic             o_dir_next
);

  // One extra bit so pos+spd can never wrap past the limit comparison.
  logic [POS_W:0] pos_w, spd_w, lim_w, sum_w;

  assign pos_w = {1'b0, i_pos};
  assign spd_w = {1'b0, i_spd};
  assign lim_w = {1'b0, i_lim};
  assign sum_w = pos_w + spd_w;

  always_comb begin
    o_pos_next = i_pos;
    o_dir_next = i_dir;
    if (!i_dir) begin
      if (sum_w >= lim_w) begin
        o_pos_next = i_lim;
        o_dir_next = 1'b1;
      end else begin
        o_pos_next = sum_w[POS_W-1:0];
      end
    end else begin
      if (pos_w <= spd_w) begin
        o_pos_next = '0;
        o_dir_next = 1'b0;
      end else begin
        o_pos_next = i_pos - i_spd;
      end
    end
  end

endmodule

// File: rtl/ball_multi.sv
// rtl/ball_multi.sv - multi-ball bouncer with registered RGB pixel output
// Purpose: holds NUM_BALLS balls, steps them one per cycle after each vsync
//          rise, and renders the colour of the lowest-index covering ball.
// Ports:   i_clk, i_rst_n (async, active-low), i_vsync, i_freeze, i_visible,
//          i_hpos, i_vpos in; o_rgb (bit0 R, bit1 G, bit2 B), o_busy out.
module ball_multi
  import ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int BALL_SIZE = 4,
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int POS_W     = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_freeze,
  input  logic             i_visible,
  input  logic [POS_W-1:0] i_hpos,
  input  logic [POS_W-1:0] i_vpos,
  output logic [2:0]       o_rgb,
  output logic             o_busy
);

  localparam int PW1   = POS_W + 1;
  localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [POS_W-1:0] LIM_X    = POS_W'(H_VISIBLE - BALL_SIZE);
  localparam logic [POS_W-1:0] LIM_Y    = POS_W'(V_VISIBLE - BALL_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);
  localparam logic [PW1-1:0]   SIZE_W   = PW1'(BALL_SIZE);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            vsync_q;
  logic [2:0]                      rgb_q, rgb_d, hit_rgb;
  logic [NUM_BALLS-1:0][POS_W-1:0] x_q, y_q;
  logic [NUM_BALLS-1:0]            dir_x_q, dir_y_q;

  logic [POS_W-1:0] x_cur, y_cur, spd_x_cur, spd_y_cur, x_nxt, y_nxt;
  logic             dir_x_nxt, dir_y_nxt;

  // The single pair of steppers is time-shared across balls through idx.
  assign x_cur     = x_q[idx_q];
  assign y_cur     = y_q[idx_q];
  assign spd_x_cur = POS_W'(ball_spd_x(int'(idx_q)));
  assign spd_y_cur = POS_W'(ball_spd_y(int'(idx_q)));

  ball_axis_step #(.POS_W(POS_W)) u_step_x (
    .i_pos      (x_cur),
    .i_dir      (dir_x_q[idx_q]),
    .i_spd      (spd_x_cur),
    .i_lim      (LIM_X),
    .o_pos_next (x_nxt),
    .o_dir_next (dir_x_nxt)
  );

  ball_axis_step #(.POS_W(POS_W)) u_step_y (
    .i_pos      (y_cur),
    .i_dir      (dir_y_q[idx_q]),
    .i_spd      (spd_y_cur),
    .i_lim      (LIM_Y),
    .o_pos_next (y_nxt),
    .o_dir_next (dir_y_nxt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        // Rises arriving while UPDATE runs never reach this branch.
        if (i_vsync && !vsync_q && !i_freeze) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end
      end
      ST_UPDATE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan from the highest index down so the lowest covering index wins.
  always_comb begin
    hit_rgb = RGB_BLACK;
    for (int k = NUM_BALLS - 1; k >= 0; k--) begin
      if (({1'b0, i_hpos} >= {1'b0, x_q[k]}) &&
          ({1'b0, i_hpos} <  ({1'b0, x_q[k]} + SIZE_W)) &&
          ({1'b0, i_vpos} >= {1'b0, y_q[k]}) &&
          ({1'b0, i_vpos} <  ({1'b0, y_q[k]} + SIZE_W))) begin
        hit_rgb = ball_colour(k);
      end
    end
    rgb_d = i_visible ? hit_rgb : RGB_BLACK;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      // Held at 1 so a vsync already high at reset release is not an edge.
      vsync_q <= 1'b1;
      rgb_q   <= RGB_BLACK;
      dir_x_q <= '0;
      dir_y_q <= '0;
      for (int k = 0; k < NUM_BALLS; k++) begin
        x_q[k] <= POS_W'(ball_init_x(k));
        y_q[k] <= POS_W'(ball_init_y(k));
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_q <= i_vsync;
      rgb_q   <= rgb_d;
      if (state_q == ST_UPDATE) begin
        x_q[idx_q]     <= x_nxt;
        y_q[idx_q]     <= y_nxt;
        dir_x_q[idx_q] <= dir_x_nxt;
        dir_y_q[idx_q] <= dir_y_nxt;
      end
    end
  end

  assign o_rgb  = rgb_q;
  assign o_busy = (state_q == ST_UPDATE);

endmodule

// File: tb/tb_ball_multi.sv
// tb/tb_ball_multi.sv - self-checking bench for ball_multi
module tb_ball_multi;

  localparam int H  = 80;
  localparam int V  = 60;
  localparam int BS = 4;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst_n, vsync, freeze, visible;
  logic [PW-1:0] hpos, vpos;
  logic [2:0]    rgb4, rgb2;
  logic          busy4, busy2;

  always #5 clk = ~clk;

  ball_multi #(.NUM_BALLS(4), .BALL_SIZE(BS), .H_VISIBLE(H), .V_VISIBLE(V), .POS_W(PW)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_freeze(freeze), .i_visible(visible),
    .i_hpos(hpos), .i_vpos(vpos), .o_rgb(rgb4), .o_busy(busy4)
  );

  ball_multi #(.NUM_BALLS(2), .BALL_SIZE(BS), .H_VISIBLE(H), .V_VISIBLE(V), .POS_W(PW)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_freeze(freeze), .i_visible(visible),
    .i_hpos(hpos), .i_vpos(vpos), .o_rgb(rgb2), .o_busy(busy2)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: instance 0 has 4 balls, instance 1 has 2.
  int nb[2] = '{4, 2};
  int mx[2][4], my[2][4], mdx[2][4], mdy[2][4];

  typedef struct {
    int h;
    int v;
    bit vis;
    int exp_rgb;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        mx[i][k] = 16 * k + 16;
        my[i][k] = 12 * k + 12;
        mdx[i][k] = 0;
        mdy[i][k] = 0;
      end
  endtask

  task automatic axis(inout int p, inout int d, input int s, input int lim);
    if (d == 0) begin
      if (p + s >= lim) begin p = lim; d = 1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 0; end
      else p = p - s;
    end
  endtask

  task automatic model_frame;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < nb[i]; k++) begin
        axis(mx[i][k], mdx[i][k], (k % 4) + 1, H - BS);
        axis(my[i][k], mdy[i][k], ((k + 1) % 4) + 1, V - BS);
      end
  endtask

  function automatic int model_rgb(input int i, input int h, input int v, input bit vis);
    if (!vis) return 0;
    for (int k = 0; k < nb[i]; k++)
      if (h >= mx[i][k] && h < mx[i][k] + BS && v >= my[i][k] && v < my[i][k] + BS)
        return (k % 7) + 1;
    return 0;
  endfunction

  task automatic check_positions(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_b4x%0d", tag, k), int'(dut4.x_q[k]), mx[0][k]);
      check($sformatf("%s_b4y%0d", tag, k), int'(dut4.y_q[k]), my[0][k]);
      check($sformatf("%s_b4dx%0d", tag, k), int'(dut4.dir_x_q[k]), mdx[0][k]);
      check($sformatf("%s_b4dy%0d", tag, k), int'(dut4.dir_y_q[k]), mdy[0][k]);
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_b2x%0d", tag, k), int'(dut2.x_q[k]), mx[1][k]);
      check($sformatf("%s_b2y%0d", tag, k), int'(dut2.y_q[k]), my[1][k]);
    end
  endtask

  // One vsync pulse; returns the number of cycles busy was observed high.
  task automatic frame(output int busy_n);
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy4) break;
      busy_n++;
      tick;
    end
    tick;
    if (!freeze) model_frame();
  endtask

  task automatic probe(input int h, input int v, input bit vis);
    hpos = PW'(h);
    vpos = PW'(v);
    visible = vis;
    tick;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bn;
    int f_found;
    bit found;
    int tx[2], ty[2], tdx[2], tdy[2];
    int h, v;

    tbl[0]  = '{16, 12, 1'b1, 1};
    tbl[1]  = '{19, 15, 1'b1, 1};
    tbl[2]  = '{20, 12, 1'b1, 0};
    tbl[3]  = '{15, 12, 1'b1, 0};
    tbl[4]  = '{19, 16, 1'b1, 0};
    tbl[5]  = '{32, 24, 1'b1, 2};
    tbl[6]  = '{35, 27, 1'b1, 2};
    tbl[7]  = '{48, 36, 1'b1, 3};
    tbl[8]  = '{64, 48, 1'b1, 4};
    tbl[9]  = '{67, 51, 1'b1, 4};
    tbl[10] = '{68, 51, 1'b1, 0};
    tbl[11] = '{64, 48, 1'b0, 0};
    tbl[12] = '{0,  0,  1'b1, 0};

    rst_n = 1'b0; vsync = 1'b0; freeze = 1'b0; visible = 1'b1; hpos = '0; vpos = '0;
    model_reset();
    tick;
    check("rst_busy", int'(busy4), 0);
    check("rst_rgb", int'(rgb4), 0);
    tick;
    rst_n = 1'b1;
    tick;
    check("idle_busy", int'(busy4), 0);
    check_positions("rst");

    foreach (tbl[i]) begin
      probe(tbl[i].h, tbl[i].v, tbl[i].vis);
      check($sformatf("tbl%0d_rgb", i), int'(rgb4), tbl[i].exp_rgb);
    end

    // First frame: ball 0 to (17,14), busy exactly 4 cycles.
    frame(bn);
    check("f1_busy_cycles", bn, 4);
    check("f1_b0x", int'(dut4.x_q[0]), 17);
    check("f1_b0y", int'(dut4.y_q[0]), 14);
    probe(17, 14, 1'b1);
    check("f1_pix", int'(rgb4), 1);

    frame(bn);
    frame(bn);
    check("f3_b3x", int'(dut4.x_q[3]), 76);
    check("f3_b3dx", int'(dut4.dir_x_q[3]), 1);
    frame(bn);
    check("f4_b3x", int'(dut4.x_q[3]), 72);
    for (int f = 5; f <= 8; f++) frame(bn);
    check("f8_b3y", int'(dut4.y_q[3]), 56);
    check("f8_b3dy", int'(dut4.dir_y_q[3]), 1);
    frame(bn);
    check("f9_b3y", int'(dut4.y_q[3]), 55);
    check_positions("f9");

    // Freeze blocks sweep start.
    freeze = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame(bn);
      check("frz_busy_cycles", bn, 0);
      check("frz_busy2", int'(busy2), 0);
    end
    freeze = 1'b0;
    check_positions("frz");

    // Second rise during UPDATE is ignored.
    vsync = 1'b1; tick;
    vsync = 1'b0; tick;
    vsync = 1'b1; tick;
    vsync = 1'b0;
    bn = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy4) break;
      bn++;
      tick;
    end
    tick; tick;
    check("dbl_busy_after", int'(busy4), 0);
    check("dbl_busy_cycles", bn, 2);
    model_frame();
    check_positions("dbl");

    // Invisible ball pixel renders black.
    probe(mx[0][1], my[0][1], 1'b0);
    check("invis_rgb", int'(rgb4), 0);
    probe(mx[0][1], my[0][1], 1'b1);
    check("vis_rgb", int'(rgb4), model_rgb(0, mx[0][1], my[0][1], 1'b1));

    // Randomized frames and pixel probes against the model.
    for (int it = 0; it < 30; it++) begin
      freeze = ($urandom_range(0, 3) == 0);
      frame(bn);
      freeze = 1'b0;
      check_positions($sformatf("rnd%0d", it));
      for (int p = 0; p < 4; p++) begin
        int k;
        bit vis;
        k = $urandom_range(0, 3);
        h = mx[0][k] + $urandom_range(0, 7) - 2;
        v = my[0][k] + $urandom_range(0, 7) - 2;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        vis = ($urandom_range(0, 4) != 0);
        probe(h, v, vis);
        check("rnd_rgb4", int'(rgb4), model_rgb(0, h, v, vis));
        check("rnd_rgb2", int'(rgb2), model_rgb(1, h, v, vis));
      end
    end

    // Overlap on the two-ball instance: find the frame in the model, then step there.
    for (int k = 0; k < 2; k++) begin
      tx[k] = mx[1][k]; ty[k] = my[1][k]; tdx[k] = mdx[1][k]; tdy[k] = mdy[1][k];
    end
    found = 1'b0;
    f_found = 0;
    for (int f = 1; f <= 3000 && !found; f++) begin
      for (int k = 0; k < 2; k++) begin
        axis(tx[k], tdx[k], (k % 4) + 1, H - BS);
        axis(ty[k], tdy[k], ((k + 1) % 4) + 1, V - BS);
      end
      if ((tx[0] - tx[1] < BS) && (tx[1] - tx[0] < BS) &&
          (ty[0] - ty[1] < BS) && (ty[1] - ty[0] < BS)) begin
        found = 1'b1;
        f_found = f;
      end
    end
    check("ovl_found", int'(found), 1);
    for (int f = 0; f < f_found; f++) frame(bn);
    check_positions("ovl");
    h = (mx[1][0] > mx[1][1]) ? mx[1][0] : mx[1][1];
    v = (my[1][0] > my[1][1]) ? my[1][0] : my[1][1];
    probe(h, v, 1'b1);
    if (found) check("ovl_rgb", int'(rgb2), 1);

    // Async reset in the middle of a sweep.
    probe(mx[0][0], my[0][0], 1'b1);
    vsync = 1'b1; tick;
    vsync = 1'b0; tick;
    check("mid_busy", int'(busy4), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", int'(busy4), 0);
    check("arst_busy2", int'(busy2), 0);
    check("arst_rgb", int'(rgb4), 0);
    check_positions("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tick; tick;
    check("post_rst_busy", int'(busy4), 0);
    check_positions("postrst");
    frame(bn);
    check("post_rst_busy_cycles", bn, 4);
    check_positions("postrst_f1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
